// File: rtl/alu_ctrl_decode_stage.sv
// RV32I decode stage: ALUOp, operand selects, register indices and immediate
// registered behind one valid/ready slot. Illegal flagging under DECODE_ILLEGAL_EN.
module alu_ctrl_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [1:0]      alu_src_a,
  output logic            alu_src_b,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign f_rs1 = instr[19:15];
  assign f_rs2 = instr[24:20];
  assign f_rd  = instr[11:7];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};
  assign shamt = {27'b0, instr[24:20]};

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;

  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);

  logic [3:0]      dec_op;
  logic [1:0]      dec_sa;
  logic            dec_sb;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            bad;

  always_comb begin
    dec_op  = 4'b0000;
    dec_sa  = 2'b00;
    dec_sb  = 1'b0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    dec_rd  = 5'd0;
    dec_imm = '0;
    bad     = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_rd  = f_rd;
        dec_op  = {instr[30], f3};
        bad = !((f7 == 7'h00) ||
                ((f7 == 7'h20) &&
                 ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      is_i: begin
        dec_sb  = 1'b1;
        dec_rs1 = f_rs1;
        dec_rd  = f_rd;
        dec_imm = imm_i;
        dec_op  = {1'b0, f3};
        if (f3 == 3'b101) begin
          dec_op  = {instr[30], 3'b101};
          dec_imm = shamt;
          bad = !((f7 == 7'h00) || (f7 == 7'h20));
        end else if (f3 == 3'b001) begin
          dec_op  = 4'b0001;
          dec_imm = shamt;
          bad = (f7 != 7'h00);
        end
      end
      is_ld: begin
        dec_sb  = 1'b1;
        dec_rs1 = f_rs1;
        dec_rd  = f_rd;
        dec_imm = imm_i;
      end
      is_st: begin
        dec_sb  = 1'b1;
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_imm = imm_s;
      end
      is_br: begin
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_imm = imm_b;
        unique case (f3[2:1])
          2'b00:   dec_op = 4'b1000;
          2'b10:   dec_op = 4'b0010;
          2'b11:   dec_op = 4'b0011;
          default: bad = 1'b1;
        endcase
      end
      is_lui: begin
        dec_sa  = 2'b10;
        dec_sb  = 1'b1;
        dec_rd  = f_rd;
        dec_imm = imm_u;
      end
      is_auipc: begin
        dec_sa  = 2'b01;
        dec_sb  = 1'b1;
        dec_rd  = f_rd;
        dec_imm = imm_u;
      end
      is_jal: begin
        dec_sa  = 2'b01;
        dec_sb  = 1'b1;
        dec_rd  = f_rd;
        dec_imm = imm_j;
      end
      is_jalr: begin
        dec_sb  = 1'b1;
        dec_rs1 = f_rs1;
        dec_rd  = f_rd;
        dec_imm = imm_i;
      end
      default: bad = 1'b1;
    endcase
    // unsupported encodings collapse to a harmless ADD with no writeback
    if (bad) begin
      dec_op = 4'b0000;
      dec_rd = 5'd0;
    end
  end

  logic            out_valid_q, out_valid_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [1:0]      src_a_q, src_a_d;
  logic            src_b_q, src_b_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)         out_valid_d = 1'b0;
    else if (in_ready) out_valid_d = in_valid;
    alu_op_d = load ? dec_op  : alu_op_q;
    src_a_d  = load ? dec_sa  : src_a_q;
    src_b_d  = load ? dec_sb  : src_b_q;
    rs1_d    = load ? dec_rs1 : rs1_q;
    rs2_d    = load ? dec_rs2 : rs2_q;
    rd_d     = load ? dec_rd  : rd_q;
    imm_d    = load ? dec_imm : imm_q;
    pc_d     = load ? pc_in   : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= 4'b0000;
      src_a_q     <= 2'b00;
      src_b_q     <= 1'b0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic illegal_q, illegal_d;

  assign illegal_d = load ? bad : illegal_q;

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_src_a = src_a_q;
  assign alu_src_b = src_b_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Directed bench for alu_ctrl_decode_stage: decode vectors, stall, flush,
// and illegal handling (expectations follow DECODE_ILLEGAL_EN).
module tb_alu_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_ctrl_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .pc_out(pc_out),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v,
                       input logic [31:0] i,
                       input logic [31:0] p);
    in_valid = v;
    instr    = i;
    pc_in    = p;
  endtask

`ifdef DECODE_ILLEGAL_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_srca", 32'(alu_src_a), 32'd0);
    chk("rst_srcb", 32'(alu_src_b), 32'd0);
    chk("rst_rs1", 32'(rs1), 32'd0);
    chk("rst_rs2", 32'(rs2), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);

    // add x3,x1,x2 then sub back-to-back
    offer(1'b1, 32'h002081B3, 32'h100);
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(alu_op), 32'h0);
    chk("add_rs1", 32'(rs1), 32'd1);
    chk("add_rs2", 32'(rs2), 32'd2);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_srcb", 32'(alu_src_b), 32'd0);
    chk("add_srca", 32'(alu_src_a), 32'd0);
    chk("add_pc", pc_out, 32'h100);
    chk("add_ill", 32'(illegal), 32'd0);
    offer(1'b1, 32'h402081B3, 32'h104);
    tick();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(alu_op), 32'h8);
    chk("sub_pc", pc_out, 32'h104);

    // srai x5,x6,3
    offer(1'b1, 32'h40335293, 32'h108);
    tick();
    chk("srai_op", 32'(alu_op), 32'hD);
    chk("srai_imm", imm, 32'h3);
    chk("srai_srcb", 32'(alu_src_b), 32'd1);
    chk("srai_rs1", 32'(rs1), 32'd6);
    chk("srai_rs2", 32'(rs2), 32'd0);
    chk("srai_rd", 32'(rd), 32'd5);

    // addi x1,x0,-1
    offer(1'b1, 32'hFFF00093, 32'h10C);
    tick();
    chk("addi_op", 32'(alu_op), 32'h0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(rd), 32'd1);

    // lui x7,0x12345
    offer(1'b1, 32'h123453B7, 32'h110);
    tick();
    chk("lui_srca", 32'(alu_src_a), 32'd2);
    chk("lui_srcb", 32'(alu_src_b), 32'd1);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", 32'(rd), 32'd7);
    chk("lui_rs1", 32'(rs1), 32'd0);

    // bltu x1,x2,+8
    offer(1'b1, 32'h0020E463, 32'h114);
    tick();
    chk("bltu_op", 32'(alu_op), 32'h3);
    chk("bltu_rd", 32'(rd), 32'd0);
    chk("bltu_imm", imm, 32'h8);
    chk("bltu_srcb", 32'(alu_src_b), 32'd0);
    chk("bltu_rs2", 32'(rs2), 32'd2);

    // sw x2,-4(x1)
    offer(1'b1, 32'hFE20AE23, 32'h118);
    tick();
    chk("sw_op", 32'(alu_op), 32'h0);
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_rd", 32'(rd), 32'd0);
    chk("sw_rs2", 32'(rs2), 32'd2);

    // stall: hold add while sub waits
    offer(1'b1, 32'h002081B3, 32'h200);
    tick();
    out_ready = 1'b0;
    offer(1'b1, 32'h402081B3, 32'h204);
    #1;
    chk("stall_inrdy", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_op", 32'(alu_op), 32'h0);
      chk("stall_pc", pc_out, 32'h200);
      chk("stall_inrdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("unstall_op", 32'(alu_op), 32'h8);
    chk("unstall_pc", pc_out, 32'h204);
    chk("unstall_valid", 32'(out_valid), 32'd1);

    // flush drops the held and the offered instruction
    flush = 1'b1;
    offer(1'b1, 32'h123453B7, 32'h300);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flush_drop1", 32'(out_valid), 32'd0);
    tick();
    chk("flush_drop2", 32'(out_valid), 32'd0);

    // unknown opcode and mul (unsupported funct7)
    offer(1'b1, 32'hFFFFFFFF, 32'h400);
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'(EXP_ILL));
    chk("ill_op", 32'(alu_op), 32'h0);
    chk("ill_rd", 32'(rd), 32'd0);
    offer(1'b1, 32'h022081B3, 32'h404);
    tick();
    chk("mul_flag", 32'(illegal), 32'(EXP_ILL));
    chk("mul_op", 32'(alu_op), 32'h0);
    chk("mul_rd", 32'(rd), 32'd0);
    offer(1'b1, 32'h002081B3, 32'h408);
    tick();
    chk("legal_flag", 32'(illegal), 32'd0);
    chk("legal_rd", 32'(rd), 32'd3);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decode_stage.md
Name: alu_ctrl_decode_stage

Overview:
- Decode-side producer of the 4-bit ALUOp code consumed by the execute-stage ALU. It is the ID/EX boundary of the segmented RV32I core.
- Takes a fetched instruction and its PC, then registers the following into a single valid/ready pipeline stage with stall and flush: ALUOp, operand selects, register indices, the sign-extended immediate, and an illegal flag.
- Latency is 1 cycle from accept to out_valid.

Parameters:
- XLEN, 32, datapath width of pc and imm. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instr/pc_in are valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  RV32I instruction word
- pc_in  in  XLEN  PC of instr
- flush  in  1  kill the registered and the incoming instruction (branch mispredict)
- out_valid  out  1  registered outputs are valid
- out_ready  in  1  execute stage accepts this cycle
- alu_op  out  4  ALUOp code (encoding below)
- alu_src_a  out  2  ALU A select: 00=rs1, 01=pc, 10=zero
- alu_src_b  out  1  ALU B select: 0=rs2, 1=imm
- rs1, rs2, rd  out  5 each  register indices (0 when unused)
- imm  out  XLEN  sign-extended immediate
- pc_out  out  XLEN  registered pc_in
- illegal  out  1  unsupported encoding (see Optional Feature)

Behaviour:
- ALUOp encoding (fixed):
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Any other code is never produced.
- Reset: when rst=1 at a clock edge, out_valid, alu_op, alu_src_a, alu_src_b, rs1, rs2, rd, imm, pc_out and illegal all become 0. rst overrides flush and the handshake.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Load enable = in_ready & !flush. When enabled: out_valid <= in_valid, and all data outputs <= decoded values.
  - Data outputs may load while in_valid=0, but they are don't-care while out_valid=0.
- Stall: while out_valid=1 & out_ready=0, every output holds its value bit-exact and in_ready=0.
- Flush: at the edge, out_valid <= 0. Any instruction offered in the same cycle is dropped even if in_ready=1. Flush has priority over load.
- Simultaneous handshakes: out_ready=1 & in_valid=1 with out_valid=1 gives back-to-back transfer, with no bubble.
- Decode by opcode (instr[6:0]):
  - 0110011 R: alu_op = {instr[30], funct3}; src_a=00, src_b=0.
  - 0010011 I-ALU:
    - funct3=101: alu_op = {instr[30], 101}, imm = shamt zero-extended.
    - funct3=001: alu_op = 0001.
    - Otherwise: alu_op = {0, funct3}.
    - In all cases src_b=1 and rs2=0.
  - 0000011 load, 0100011 store: alu_op=0000, src_b=1, imm=I-type or S-type respectively.
  - 1100011 branch:
    - BEQ/BNE give 1000, BLT/BGE give 0010, BLTU/BGEU give 0011.
    - src_b=0; imm = B-type (bit0=0); rd=0.
  - 0110111 LUI: src_a=10, src_b=1, alu_op=0000, imm={instr[31:12], 12'b0}.
  - 0010111 AUIPC: src_a=01, src_b=1, alu_op=0000, imm = U-type.
  - 1101111 JAL: src_a=01, src_b=1, alu_op=0000, imm = J-type.
  - 1100111 JALR: src_a=00, src_b=1, alu_op=0000, imm = I-type.
- Immediates are sign-extended from instr[31]. Fields not used by a format are driven to 0.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: illegal=1 for any of the following:
  - an opcode not listed above;
  - R-type with funct7 not 0000000 and not 0100000;
  - R-type with funct7=0100000 and funct3 not 000 or 101;
  - I-shift with an invalid funct7;
  - branch funct3 of 010 or 011.
  - On illegal, alu_op=0000, rd=0 and out_valid behaves normally.
- Undefined: the illegal port is tied to 0, and unsupported encodings decode as ADD with rd=0.

Test Plan:
- rst=1 for 2 cycles, then rst=0 -> out_valid=0, all outputs 0, in_ready=1.
- instr=0x002081B3 (add x3,x1,x2), in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_op=0000, rs1=1, rs2=2, rd=3, src_b=0. Then 0x402081B3 back-to-back -> alu_op=1000 on the following cycle.
- instr=0x40335293 (srai x5,x6,3) -> alu_op=1101, imm=0x00000003, src_b=1, rs1=6, rd=5. instr=0xFFF00093 (addi x1,x0,-1) -> alu_op=0000, imm=0xFFFFFFFF.
- instr=0x123453B7 (lui x7,0x12345) -> src_a=10, imm=0x12345000, rd=7. BLTU encoding -> alu_op=0011, rd=0.
- Load add, then hold out_ready=0 for 3 cycles while offering sub -> in_ready=0 and outputs unchanged. out_ready=1 -> sub appears the next cycle.
- out_valid=1 with flush=1 and in_valid=1 -> next cycle out_valid=0 and the offered instruction never appears. With DECODE_ILLEGAL_EN defined, instr=0xFFFFFFFF -> illegal=1, alu_op=0000.
